// File: rtl/timer_pkg.sv
// Shared definitions for the programmable interval timer controller:
// FSM state encoding, mode encoding and default field widths.
package timer_pkg;

   localparam int DATA_WIDTH_DEF     = 16;
   localparam int PRESCALE_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the interval timer: counts 0..limit and wraps, raising
// tick while the count sits at limit. A synchronous clear parks it at 0.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic [PRESCALE_WIDTH-1:0] limit,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] count_q;
   logic [PRESCALE_WIDTH-1:0] count_d;

   assign tick = (count_q == limit);

   // Next count: hold at zero while cleared, otherwise count and wrap at limit.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (tick) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/timer_sequencer.sv
// Programmable interval timer controller. Sequences an external counter
// (enable/clear in, DATA back) through IDLE -> CLEAR -> RUN, applying a
// prescaler, one-shot or periodic reload, and an EXPIRE pulse per expiry.
// Optional capture port: define TIMER_SEQUENCER_CAPTURE_EN to add CAPTURE and
// CAPTURE_DATA, which samples CNT_DATA on a CAPTURE pulse while running.
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
   input  logic                      CLOCK,
   input  logic                      RESET_N,
   input  logic                      START,
   input  logic                      STOP,
   input  logic                      MODE,
   input  logic [DATA_WIDTH-1:0]     PERIOD,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   input  logic [DATA_WIDTH-1:0]     CNT_DATA,
   output logic                      CNT_ENABLE,
   output logic                      CNT_CLEAR,
   output logic                      EXPIRE,
   output logic                      BUSY
`ifdef TIMER_SEQUENCER_CAPTURE_EN
   ,
   input  logic                      CAPTURE,
   output logic [DATA_WIDTH-1:0]     CAPTURE_DATA
`endif
);

   state_t                    state_q,     state_d;
   logic                      mode_q,      mode_d;
   logic [DATA_WIDTH-1:0]     period_q,    period_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q,  prescale_d;
   logic                      expire_q,    expire_d;
   logic                      cnt_clear_q, cnt_clear_d;

   logic [DATA_WIDTH-1:0]     period_eff;
   logic                      terminal;
   logic                      tick;

   // A zero period is treated as one tick so the timer always expires.
   assign period_eff = (period_q == '0) ? DATA_WIDTH'(1) : period_q;
   assign terminal   = (state_q == RUN) && (CNT_DATA == period_eff);

   timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .clear (state_q != RUN),
      .limit (prescale_q),
      .tick  (tick)
   );

   assign CNT_ENABLE = (state_q == RUN) && tick && !terminal;
   assign CNT_CLEAR  = cnt_clear_q;
   assign EXPIRE     = expire_q;
   assign BUSY       = (state_q == CLEAR) || (state_q == RUN);

   // Next-state, config latch and expiry decode; STOP overrides START and terminal.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      expire_d   = terminal && !STOP;
      if (STOP) begin
         state_d = IDLE;
      end else if (START) begin
         mode_d     = MODE;
         period_d   = PERIOD;
         prescale_d = PRESCALE;
         state_d    = CLEAR;
      end else begin
         case (state_q)
            CLEAR:   state_d = RUN;
            RUN:     if (terminal) state_d = (mode_q == MODE_ONESHOT) ? IDLE : CLEAR;
            default: state_d = IDLE;
         endcase
      end
      // The counter is held cleared everywhere except RUN.
      cnt_clear_d = (state_d != RUN);
   end

   // State, latched configuration and registered outputs.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         mode_q      <= MODE_ONESHOT;
         period_q    <= '0;
         prescale_q  <= '0;
         expire_q    <= 1'b0;
         cnt_clear_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         period_q    <= period_d;
         prescale_q  <= prescale_d;
         expire_q    <= expire_d;
         cnt_clear_q <= cnt_clear_d;
      end
   end

`ifdef TIMER_SEQUENCER_CAPTURE_EN
   logic [DATA_WIDTH-1:0] capture_data_q, capture_data_d;

   assign CAPTURE_DATA = capture_data_q;

   // Snapshot the counter on a CAPTURE pulse, but only while running.
   always_comb begin
      capture_data_d = capture_data_q;
      if (CAPTURE && (state_q == RUN)) begin
         capture_data_d = CNT_DATA;
      end
   end

   // Capture register.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         capture_data_q <= '0;
      end else begin
         capture_data_q <= capture_data_d;
      end
   end
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer with a behavioural counter.
// Expected BUSY/EXPIRE/CNT_CLEAR/CNT_ENABLE/CNT_DATA per cycle are derived
// from the timing rules (START at t: CLEAR at t+1, RUN for L+1 cycles,
// L = max(PERIOD,1)*(PRESCALE+1), expiry one cycle after the last RUN cycle).
module tb_timer_sequencer;
   import timer_pkg::*;

   localparam int DW   = 16;
   localparam int PW   = 8;
   localparam int MAXC = 4000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          mode = 1'b0;
   logic [DW-1:0] period = '0;
   logic [PW-1:0] prescale = '0;
   logic [DW-1:0] cnt_data;
   logic          cnt_enable, cnt_clear, expire, busy;
`ifdef TIMER_SEQUENCER_CAPTURE_EN
   logic          capture = 1'b0;
   logic [DW-1:0] capture_data;
`endif

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int n_expire = 0;
   int exp_times[$];

   bit exp_busy [MAXC];
   bit exp_clr  [MAXC];
   bit exp_en   [MAXC];
   bit exp_exp  [MAXC];
   int exp_data [MAXC];

   timer_sequencer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .CLOCK      (clk),
      .RESET_N    (rst_n),
      .START      (start),
      .STOP       (stop),
      .MODE       (mode),
      .PERIOD     (period),
      .PRESCALE   (prescale),
      .CNT_DATA   (cnt_data),
      .CNT_ENABLE (cnt_enable),
      .CNT_CLEAR  (cnt_clear),
      .EXPIRE     (expire),
      .BUSY       (busy)
`ifdef TIMER_SEQUENCER_CAPTURE_EN
      ,
      .CAPTURE      (capture),
      .CAPTURE_DATA (capture_data)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for the TIMER_COUNTER: synchronous clear, count on enable.
   always_ff @(posedge clk) begin
      if (cnt_clear) cnt_data <= '0;
      else if (cnt_enable) cnt_data <= cnt_data + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic model_reset_from(input int c0);
      for (int c = c0; c < MAXC; c++) begin
         if (c >= 0) begin
            exp_busy[c] = 1'b0;
            exp_clr[c]  = 1'b1;
            exp_en[c]   = 1'b0;
            exp_exp[c]  = 1'b0;
            exp_data[c] = -1;
         end
      end
   endtask

   // START sampled in cycle t: a terminal in cycle t still yields EXPIRE at t+1.
   task automatic model_start(input int t, input bit m, input int p, input int k);
      int  pe, len, rs;
      bit  keep;
      pe = (p == 0) ? 1 : p;
      len = pe * (k + 1);
      keep = (t + 1 < MAXC) ? exp_exp[t+1] : 1'b0;
      model_reset_from(t + 1);
      if (t + 1 < MAXC) exp_exp[t+1] = keep;
      for (int j = 0; j < MAXC; j++) begin
         rs = t + 2 + j * (len + 2);
         if (rs >= MAXC) break;
         exp_busy[rs-1] = 1'b1;
         for (int r = 0; r <= len; r++) begin
            if (rs + r < MAXC) begin
               exp_busy[rs+r] = 1'b1;
               exp_clr[rs+r]  = 1'b0;
               exp_en[rs+r]   = (r < len) && (((r + 1) % (k + 1)) == 0);
               exp_data[rs+r] = r / (k + 1);
            end
         end
         if (rs + len + 1 < MAXC) exp_exp[rs+len+1] = 1'b1;
         if (m == MODE_ONESHOT) break;
      end
   endtask

   task automatic check_cycle();
      if (cyc < MAXC) begin
         chk("busy", busy, exp_busy[cyc]);
         chk("expire", expire, exp_exp[cyc]);
         chk("cnt_clear", cnt_clear, exp_clr[cyc]);
         chk("cnt_enable", cnt_enable, exp_en[cyc]);
         if (exp_data[cyc] >= 0) chk("cnt_data", cnt_data, exp_data[cyc]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (expire === 1'b1) begin
         n_expire++;
         exp_times.push_back(cyc);
      end
      check_cycle();
   endtask

   // One cycle of stimulus; config inputs are scrambled afterwards since they
   // must be ignored outside the START cycle.
   task automatic drive(input bit st, input bit sp, input bit m, input int p, input int k);
      start = st;
      stop = sp;
      mode = m;
      period = DW'(p);
      prescale = PW'(k);
      if (sp) model_reset_from(cyc + 1);
      else if (st) model_start(cyc, m, p, k);
      if (st || sp)
         $display("cyc %0d: start=%0d stop=%0d mode=%0d period=%0d prescale=%0d",
                  cyc, st, sp, m, p, k);
      step();
      start = 1'b0;
      stop = 1'b0;
      mode = 1'($urandom);
      period = DW'($urandom);
      prescale = PW'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      int base, t0, r;
      model_reset_from(0);

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cnt_clear", cnt_clear, 1);
      chk("rst_busy", busy, 0);
      chk("rst_expire", expire, 0);
      chk("rst_cnt_enable", cnt_enable, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
      chk("rst_cnt_data", cnt_data, 0);

      // One-shot PERIOD=3 PRESCALE=0 started at cycle 0
      exp_times.delete();
      base = n_expire;
      drive(1'b1, 1'b0, MODE_ONESHOT, 3, 0);
      idle(55);
      chk("oneshot_count", n_expire - base, 1);
      if (exp_times.size() > 0) chk("oneshot_cycle", exp_times[0], 6);
      else chk("oneshot_seen", 0, 1);

      // Periodic PERIOD=4 PRESCALE=2: five pulses 14 cycles apart
      exp_times.delete();
      drive(1'b1, 1'b0, MODE_PERIODIC, 4, 2);
      for (int i = 0; i < 120 && exp_times.size() < 5; i++) idle(1);
      chk("periodic_pulses", exp_times.size() >= 5, 1);
      for (int i = 1; i < exp_times.size() && i < 5; i++)
         chk("periodic_spacing", exp_times[i] - exp_times[i-1], 14);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      idle(5);

      // STOP mid-RUN
      base = n_expire;
      drive(1'b1, 1'b0, MODE_ONESHOT, 6, 1);
      idle(6);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      chk("stop_busy", busy, 0);
      idle(1);
      chk("stop_cnt_data", cnt_data, 0);
      idle(20);
      chk("stop_no_expire", n_expire - base, 0);

      // STOP and START together
      base = n_expire;
      drive(1'b1, 1'b1, MODE_PERIODIC, 2, 0);
      chk("stopstart_busy", busy, 0);
      idle(15);
      chk("stopstart_no_expire", n_expire - base, 0);

      // STOP exactly in the terminal cycle (START at t, terminal at t+4)
      base = n_expire;
      drive(1'b1, 1'b0, MODE_ONESHOT, 2, 0);
      idle(3);
      chk("term_cnt_data", cnt_data, 2);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      idle(10);
      chk("term_stop_no_expire", n_expire - base, 0);

      // Restart at CNT_DATA=2 with a new period
      drive(1'b1, 1'b0, MODE_PERIODIC, 6, 0);
      idle(3);
      chk("restart_cnt_data", cnt_data, 2);
      exp_times.delete();
      t0 = cyc;
      drive(1'b1, 1'b0, MODE_PERIODIC, 5, 0);
      idle(30);
      if (exp_times.size() > 0) chk("restart_first", exp_times[0] - t0, 8);
      else chk("restart_seen", 0, 1);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      idle(4);

      // Zero period, periodic: expiry every 3 cycles
      exp_times.delete();
      drive(1'b1, 1'b0, MODE_PERIODIC, 0, 0);
      idle(20);
      chk("zero_pulses", exp_times.size() >= 5, 1);
      for (int i = 1; i < exp_times.size(); i++)
         chk("zero_spacing", exp_times[i] - exp_times[i-1], 3);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      idle(4);

`ifdef TIMER_SEQUENCER_CAPTURE_EN
      // Capture at CNT_DATA=7, then a capture in IDLE must hold the value
      drive(1'b1, 1'b0, MODE_PERIODIC, 10, 0);
      idle(8);
      chk("cap_cnt_data", cnt_data, 7);
      capture = 1'b1;
      idle(1);
      capture = 1'b0;
      chk("cap_run", capture_data, 7);
      idle(2);
      chk("cap_hold", capture_data, 7);
      drive(1'b0, 1'b1, 1'b0, 0, 0);
      idle(3);
      capture = 1'b1;
      idle(1);
      capture = 1'b0;
      chk("cap_idle", capture_data, 7);
`endif

      // Randomised START/STOP traffic against the per-cycle model
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3)
            drive(1'b1, 1'b0, 1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
         else if (r == 3)
            drive(1'b0, 1'b1, 1'b0, 0, 0);
         else if (r == 4)
            drive(1'b1, 1'b1, 1'($urandom), int'($urandom_range(0, 6)), 0);
         else
            idle(1);
      end

      // Asynchronous reset in the middle of RUN
      drive(1'b1, 1'b0, MODE_PERIODIC, 5, 1);
      idle(7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt_clear", cnt_clear, 1);
      chk("arst_busy", busy, 0);
      chk("arst_cnt_enable", cnt_enable, 0);
      model_reset_from(cyc + 1);
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      idle(3);
      chk("arst_cnt_data", cnt_data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Controller that sequences a TIMER_COUNTER instance to build a programmable interval timer.
- Drives the counter's enable and clear inputs and monitors its DATA output.
- Supports a prescaler and one-shot or periodic modes.
- Produces an expiry pulse and status for the surrounding control logic.

Parameters:
DATA_WIDTH, 16, width of the counter value and PERIOD; must match the TIMER_COUNTER instance.
PRESCALE_WIDTH, 8, width of the PRESCALE divider field.

Ports:
CLOCK  input  1  system clock, shared with the TIMER_COUNTER instance.
RESET_N  input  1  reset; asynchronous, active-low.
START  input  1  1-cycle pulse; latch config and (re)start the timer.
STOP  input  1  1-cycle pulse; abort the timer and return to IDLE.
MODE  input  1  0 = one-shot, 1 = periodic; latched on START.
PERIOD  input  DATA_WIDTH  terminal count in ticks; latched on START.
PRESCALE  input  PRESCALE_WIDTH  tick = every PRESCALE+1 clocks; latched on START.
CNT_DATA  input  DATA_WIDTH  DATA output of the TIMER_COUNTER.
CNT_ENABLE  output  1  to TIMER_COUNTER ENABLE.
CNT_CLEAR  output  1  to TIMER_COUNTER RESET (active-high), registered.
EXPIRE  output  1  1-cycle pulse per expiry.
BUSY  output  1  high in CLEAR and RUN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; CNT_CLEAR 1; CNT_ENABLE 0; EXPIRE 0; BUSY 0; prescaler 0; latched registers 0.
- States:
  - IDLE: CNT_CLEAR=1, CNT_ENABLE=0.
  - CLEAR: CNT_CLEAR=1, prescaler cleared to 0.
  - RUN: CNT_CLEAR=0, prescaler counts 0..PRESCALE_latched and wraps to 0.
- CNT_ENABLE is a combinational decode: (state==RUN) and (prescaler==PRESCALE_latched) and not terminal.
- Terminal condition: state==RUN and CNT_DATA==PERIOD_eff, where PERIOD_eff = max(PERIOD_latched, 1).
  - PERIOD=0 behaves as PERIOD=1.
  - On terminal: CNT_ENABLE forced 0 and EXPIRE is registered high for the next cycle only.
  - One-shot: next state IDLE.
  - Periodic: next state CLEAR, then RUN.
- START in any state: latch MODE/PERIOD/PRESCALE, next state CLEAR. A START while BUSY is a restart.
- STOP: next state IDLE, and no EXPIRE is produced.
- STOP wins when it coincides with START.
- STOP wins over a terminal in the same cycle, so EXPIRE stays 0.
- Latency:
  - START at cycle N -> CLEAR at N+1 -> RUN at N+2.
  - First EXPIRE at N + PERIOD_eff*(PRESCALE+1) + 3.
  - Periodic expiry spacing: PERIOD_eff*(PRESCALE+1) + 2 cycles.
- Config inputs are ignored except in the START cycle.
- No wrap-around of CNT_DATA is possible, since the terminal occurs at or before PERIOD_eff ≤ 2^DATA_WIDTH-1.
- An asynchronous reset mid-RUN clears everything immediately; CNT_CLEAR asserts asynchronously with it.

Optional Feature:
Macro TIMER_SEQUENCER_CAPTURE_EN.
- Defined: adds input CAPTURE (1-bit pulse) and output CAPTURE_DATA (DATA_WIDTH, reset 0).
  - On a CAPTURE pulse in RUN, CAPTURE_DATA <= CNT_DATA on the next edge.
  - On a CAPTURE pulse outside RUN, CAPTURE_DATA holds.
- Undefined: neither port exists, and no capture register is built.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding constants: IDLE=2'd0, CLEAR=2'd1, RUN=2'd2;
  - MODE_ONESHOT=1'b0 and MODE_PERIODIC=1'b1;
  - default DATA_WIDTH and PRESCALE_WIDTH.
- One natural sub-module, timer_prescaler: a PRESCALE_WIDTH counter with clear input and tick output.
- The TIMER_COUNTER itself is instantiated one level up, not inside this block.

Test Plan:
- Bench contents: the bench instantiates timer_sequencer together with a TIMER_COUNTER.
- Reset: RESET_N low, then release -> CNT_CLEAR=1, BUSY=0, EXPIRE=0, CNT_DATA=0.
- One-shot: MODE=0, PERIOD=3, PRESCALE=0, START at cycle 0 -> BUSY cycles 1-5, EXPIRE high only at cycle 6, IDLE after, no further EXPIRE over 50 cycles.
- Periodic with prescale: MODE=1, PERIOD=4, PRESCALE=2 -> CNT_ENABLE every 3rd RUN cycle, EXPIRE pulses exactly 14 cycles apart, 5 consecutive pulses checked.
- STOP races: STOP mid-RUN -> IDLE next cycle, CNT_DATA cleared, no EXPIRE. STOP and START together -> IDLE. STOP in the terminal cycle -> no EXPIRE.
- Restart and zero period: START at CNT_DATA=2 with new PERIOD=5 -> counter clears, expiry follows the new period. PERIOD=0, PRESCALE=0, periodic -> EXPIRE every 3 cycles.
- Capture (TIMER_SEQUENCER_CAPTURE_EN defined): CAPTURE at CNT_DATA=7 -> CAPTURE_DATA=7 next cycle. CAPTURE in IDLE -> CAPTURE_DATA unchanged.
